datapath: RTL and testbench

//  4-bit accumulator/shift datapath: ALU, accumulator register (Acc), shift

---
 rtl/datapath.sv | 137 +++++++++++++
 tb/tb_datapath.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath
//
// 4-bit accumulator/shift datapath. It contains a combinational ALU, an
// accumulator register (Acc), a shift register (Q) and an output register
// (R1). An external controller drives every select and control line on every
// cycle. R1_out is the only observable result.
//
// Ports
//   clk              rising-edge clock for all state
//   reset            asynchronous, active-low reset; clears Acc, Q and R1
//   mux2x1_1_select  ALU operand B source: 0 = data, 1 = Q
//   Acc_ps           1 = parallel load (Acc <= ALU, Q <= data), 0 = shift
//   Acc_dir          Acc shift direction when shifting: 0 = left, 1 = right
//   Q_dir            Q shift direction when shifting:   0 = left, 1 = right
//   alu_control[2:0] ALU opcode (ADD SUB AND OR XOR NOTA PASSB INCA)
//   data[3:0]        external data bus
//   mux4x1_select    R1 source: 00 Acc, 01 Q, 10 ALU result, 11 data
//   R1_out[3:0]      registered contents of R1
//
// Configuration macro
//   DATAPATH_ROTATE_EN  defined: shifts rotate, so the vacated bit receives
//                       the bit that was shifted out.
//                       undefined (default): logical shifts that fill with 0.
// -----------------------------------------------------------------------------
module datapath (
  input  logic       clk,
  input  logic       reset,
  input  logic       mux2x1_1_select,
  input  logic       Acc_ps,
  input  logic       Acc_dir,
  input  logic       Q_dir,
  input  logic [2:0] alu_control,
  input  logic [3:0] data,
  input  logic [1:0] mux4x1_select,
  output logic [3:0] R1_out
);

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_NOTA  = 3'b101,
    ALU_PASSB = 3'b110,
    ALU_INCA  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    R1_SRC_ACC  = 2'b00,
    R1_SRC_Q    = 2'b01,
    R1_SRC_ALU  = 2'b10,
    R1_SRC_DATA = 2'b11
  } r1_src_e;

  logic [3:0] acc_q, acc_d;
  logic [3:0] q_q,   q_d;
  logic [3:0] r1_q,  r1_d;
  logic [3:0] alu_b;
  logic [3:0] alu_res;

  // One-position shift. dir = 1 shifts right and dir = 0 shifts left. The
  // build-time option selects whether the vacated bit is filled with zero or
  // with the bit that was shifted out.
  function automatic logic [3:0] shift4(input logic [3:0] v, input logic dir);
`ifdef DATAPATH_ROTATE_EN
    return dir ? {v[0], v[3:1]} : {v[2:0], v[3]};
`else
    return dir ? {1'b0, v[3:1]} : {v[2:0], 1'b0};
`endif
  endfunction

  // ALU. The result is kept to 4 bits, so the carry or borrow is dropped and
  // the arithmetic wraps modulo 16.
  always_comb begin
    // NOTE: every always_comb output gets a default first. This means no
    // path through the block can leave it unassigned and infer a latch.
    alu_b   = mux2x1_1_select ? q_q : data;
    alu_res = '0;
    case (alu_op_e'(alu_control))
      ALU_ADD:   alu_res = acc_q + alu_b;
      ALU_SUB:   alu_res = acc_q - alu_b;
      ALU_AND:   alu_res = acc_q & alu_b;
      ALU_OR:    alu_res = acc_q | alu_b;
      ALU_XOR:   alu_res = acc_q ^ alu_b;
      ALU_NOTA:  alu_res = ~acc_q;
      ALU_PASSB: alu_res = alu_b;
      ALU_INCA:  alu_res = acc_q + 4'd1;
      default:   alu_res = '0;
    endcase
  end

  // Next-state logic. All three registers load on every enabled edge, and
  // they all use the pre-edge Acc and Q values. Because of this, Acc and Q
  // never see each other's new value, and R1 sees the old Acc and Q values.
  always_comb begin
    acc_d = acc_q;
    q_d   = q_q;
    r1_d  = r1_q;

    if (Acc_ps) begin
      acc_d = alu_res;
      q_d   = data;
    end else begin
      acc_d = shift4(acc_q, Acc_dir);
      q_d   = shift4(q_q, Q_dir);
    end

    case (r1_src_e'(mux4x1_select))
      R1_SRC_ACC:  r1_d = acc_q;
      R1_SRC_Q:    r1_d = q_q;
      R1_SRC_ALU:  r1_d = alu_res;
      R1_SRC_DATA: r1_d = data;
      default:     r1_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      q_q   <= '0;
      r1_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All registers
      // therefore sample their pre-edge values, whatever the statement order.
      acc_q <= acc_d;
      q_q   <= q_d;
      r1_q  <= r1_d;
    end
  end

  // R1_out is driven only by a register, so there is no combinational path
  // from the inputs to this output.
  assign R1_out = r1_q;

endmodule

// File: tb/tb_datapath.sv
// -----------------------------------------------------------------------------
// tb_datapath
//
// Directed, self-checking bench for datapath. Each task drives one scenario
// and compares R1_out against hand-computed constants. Expected values that
// depend on the shift mode are chosen with DATAPATH_ROTATE_EN.
// -----------------------------------------------------------------------------
module tb_datapath;

  logic       clk;
  logic       reset;
  logic       mux2x1_1_select;
  logic       Acc_ps;
  logic       Acc_dir;
  logic       Q_dir;
  logic [2:0] alu_control;
  logic [3:0] data;
  logic [1:0] mux4x1_select;
  logic [3:0] R1_out;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DATAPATH_ROTATE_EN
  localparam logic [3:0] EXP_Q_RIGHT_1001   = 4'b1100;
  localparam logic [3:0] EXP_ACC_RIGHT_1001 = 4'b1100;
  localparam logic [3:0] EXP_Q_LEFT2_1001   = 4'b0110;
`else
  localparam logic [3:0] EXP_Q_RIGHT_1001   = 4'b0100;
  localparam logic [3:0] EXP_ACC_RIGHT_1001 = 4'b0100;
  localparam logic [3:0] EXP_Q_LEFT2_1001   = 4'b0100;
`endif

  datapath dut (
    .clk             (clk),
    .reset           (reset),
    .mux2x1_1_select (mux2x1_1_select),
    .Acc_ps          (Acc_ps),
    .Acc_dir         (Acc_dir),
    .Q_dir           (Q_dir),
    .alu_control     (alu_control),
    .data            (data),
    .mux4x1_select   (mux4x1_select),
    .R1_out          (R1_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge. Outputs are sampled and inputs are changed
  // 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Acc = v and Q = v in one edge (PASSB of data).
  task automatic set_acc(input logic [3:0] v);
    Acc_ps = 1'b1; mux2x1_1_select = 1'b0; alu_control = 3'b110; data = v;
    step();
  endtask

  // Acc = a and Q = q. Edge 1 loads a into both registers. Edge 2 copies the
  // old Q into Acc while Q loads q.
  task automatic set_acc_q(input logic [3:0] a, input logic [3:0] q);
    set_acc(a);
    Acc_ps = 1'b1; mux2x1_1_select = 1'b1; alu_control = 3'b110; data = q;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mux2x1_1_select = 1'b0; Acc_ps = 1'b0; Acc_dir = 1'b0; Q_dir = 1'b0;
    alu_control = 3'b000; data = 4'b0000; mux4x1_select = 2'b00;
    #1;
    n_checks++;
    if (R1_out !== 4'b0000) begin
      n_fail++; $display("FAIL reset_initial: got %b expected 0000", R1_out);
    end
    // Reset must hold across a clock edge even when inputs would load.
    mux4x1_select = 2'b11; data = 4'b1111;
    step();
    n_checks++;
    if (R1_out !== 4'b0000) begin
      n_fail++; $display("FAIL reset_held: got %b expected 0000", R1_out);
    end
    reset = 1'b1;
    // Load nonzero state, then apply a reset pulse between edges.
    Acc_ps = 1'b1; alu_control = 3'b110; data = 4'b1010; mux4x1_select = 2'b11;
    step();
    n_checks++;
    if (R1_out !== 4'b1010) begin
      n_fail++; $display("FAIL reset_preload: got %b expected 1010", R1_out);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (R1_out !== 4'b0000) begin
      n_fail++; $display("FAIL reset_async: got %b expected 0000", R1_out);
    end
    reset = 1'b1;
    Acc_ps = 1'b0; mux4x1_select = 2'b00;
    step();
    n_checks++;
    if (R1_out !== 4'b0000) begin
      n_fail++; $display("FAIL reset_acc_cleared: got %b expected 0000", R1_out);
    end
    mux4x1_select = 2'b01;
    step();
    n_checks++;
    if (R1_out !== 4'b0000) begin
      n_fail++; $display("FAIL reset_q_cleared: got %b expected 0000", R1_out);
    end
  endtask

  task automatic test_load_and_pre_edge();
    Acc_ps = 1'b1; mux2x1_1_select = 1'b0; alu_control = 3'b110;
    data = 4'b0101; mux4x1_select = 2'b10;
    step();
    n_checks++;
    if (R1_out !== 4'b0101) begin
      n_fail++; $display("FAIL load_alu_path: got %b expected 0101", R1_out);
    end
    Acc_ps = 1'b0; Acc_dir = 1'b0; mux4x1_select = 2'b00;
    step();
    n_checks++;
    if (R1_out !== 4'b0101) begin
      n_fail++; $display("FAIL acc_pre_shift: got %b expected 0101", R1_out);
    end
    step();
    n_checks++;
    if (R1_out !== 4'b1010) begin
      n_fail++; $display("FAIL acc_post_shift: got %b expected 1010", R1_out);
    end
  endtask

  task automatic test_arith_wrap();
    set_acc(4'b0101);
    Acc_ps = 1'b1; alu_control = 3'b000; data = 4'b0011;
    mux2x1_1_select = 1'b0; mux4x1_select = 2'b10;
    step();
    n_checks++;
    if (R1_out !== 4'b1000) begin
      n_fail++; $display("FAIL add_0101_0011: got %b expected 1000", R1_out);
    end
    set_acc(4'b1111);
    Acc_ps = 1'b1; alu_control = 3'b000; data = 4'b0001; mux4x1_select = 2'b10;
    step();
    n_checks++;
    if (R1_out !== 4'b0000) begin
      n_fail++; $display("FAIL add_wrap: got %b expected 0000", R1_out);
    end
    // Acc now holds the wrapped sum 0000.
    alu_control = 3'b001; data = 4'b0001;
    step();
    n_checks++;
    if (R1_out !== 4'b1111) begin
      n_fail++; $display("FAIL sub_borrow: got %b expected 1111", R1_out);
    end
  endtask

  task automatic test_alu_ops();
    // A = 1100 and B = data = 1010 for every opcode.
    logic [3:0] exp_tab [8];
    exp_tab[0] = 4'b0110; exp_tab[1] = 4'b0010; exp_tab[2] = 4'b1000;
    exp_tab[3] = 4'b1110; exp_tab[4] = 4'b0110; exp_tab[5] = 4'b0011;
    exp_tab[6] = 4'b1010; exp_tab[7] = 4'b1101;
    for (int op = 0; op < 8; op++) begin
      set_acc(4'b1100);
      Acc_ps = 1'b0; mux2x1_1_select = 1'b0; alu_control = 3'(op);
      data = 4'b1010; mux4x1_select = 2'b10;
      step();
      n_checks++;
      if (R1_out !== exp_tab[op]) begin
        n_fail++;
        $display("FAIL alu_op_%0d: got %b expected %b", op, R1_out, exp_tab[op]);
      end
    end
  endtask

  task automatic test_q_shift();
    set_acc(4'b1001);
    Acc_ps = 1'b0; Q_dir = 1'b1; Acc_dir = 1'b0; mux4x1_select = 2'b00;
    step();
    mux4x1_select = 2'b01;
    step();
    n_checks++;
    if (R1_out !== EXP_Q_RIGHT_1001) begin
      n_fail++;
      $display("FAIL q_shift_right: got %b expected %b", R1_out, EXP_Q_RIGHT_1001);
    end
  endtask

  task automatic test_acc_shift();
    set_acc(4'b0110);
    Acc_ps = 1'b0; Acc_dir = 1'b0; mux4x1_select = 2'b00;
    step();
    step();
    n_checks++;
    if (R1_out !== 4'b1100) begin
      n_fail++; $display("FAIL acc_shift_left: got %b expected 1100", R1_out);
    end
    set_acc(4'b0110);
    Acc_ps = 1'b0; Acc_dir = 1'b1; mux4x1_select = 2'b00;
    step();
    step();
    n_checks++;
    if (R1_out !== 4'b0011) begin
      n_fail++; $display("FAIL acc_shift_right: got %b expected 0011", R1_out);
    end
  endtask

  // Shifts where the bit shifted out is 1. The fill value here depends on the
  // shift mode. Acc and Q shift in opposite directions on the same edges.
  task automatic test_shift_boundary();
    set_acc(4'b1001);
    Acc_ps = 1'b0; Acc_dir = 1'b1; Q_dir = 1'b0; mux4x1_select = 2'b00;
    step();
    step();
    n_checks++;
    if (R1_out !== EXP_ACC_RIGHT_1001) begin
      n_fail++;
      $display("FAIL acc_right_fill: got %b expected %b", R1_out, EXP_ACC_RIGHT_1001);
    end
    // By now Q has shifted left twice from 1001.
    mux4x1_select = 2'b01;
    step();
    n_checks++;
    if (R1_out !== EXP_Q_LEFT2_1001) begin
      n_fail++;
      $display("FAIL q_left_fill: got %b expected %b", R1_out, EXP_Q_LEFT2_1001);
    end
  endtask

  task automatic test_q_operand();
    set_acc_q(4'b0101, 4'b0011);
    Acc_ps = 1'b0; mux2x1_1_select = 1'b1; alu_control = 3'b011;
    mux4x1_select = 2'b10;
    step();
    n_checks++;
    if (R1_out !== 4'b0111) begin
      n_fail++; $display("FAIL or_acc_q: got %b expected 0111", R1_out);
    end
    set_acc_q(4'b0101, 4'b0011);
    Acc_ps = 1'b0; mux2x1_1_select = 1'b1; alu_control = 3'b101;
    mux4x1_select = 2'b10;
    step();
    n_checks++;
    if (R1_out !== 4'b1010) begin
      n_fail++; $display("FAIL not_acc: got %b expected 1010", R1_out);
    end
    mux4x1_select = 2'b11; data = 4'b1110;
    step();
    n_checks++;
    if (R1_out !== 4'b1110) begin
      n_fail++; $display("FAIL data_path: got %b expected 1110", R1_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [4];
    seq[0] = 4'b0011; seq[1] = 4'b0111; seq[2] = 4'b1100; seq[3] = 4'b0001;
    Acc_ps = 1'b0; mux4x1_select = 2'b11;
    for (int i = 0; i < 4; i++) begin
      data = seq[i];
      step();
      n_checks++;
      if (R1_out !== seq[i]) begin
        n_fail++;
        $display("FAIL b2b_data_%0d: got %b expected %b", i, R1_out, seq[i]);
      end
    end
    // Chained increments: every edge loads Acc + 1 into Acc, and R1 captures
    // each ALU result as it is produced.
    set_acc(4'b1110);
    Acc_ps = 1'b1; alu_control = 3'b111; mux4x1_select = 2'b10;
    step();
    n_checks++;
    if (R1_out !== 4'b1111) begin
      n_fail++; $display("FAIL b2b_inc_0: got %b expected 1111", R1_out);
    end
    step();
    n_checks++;
    if (R1_out !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_inc_wrap: got %b expected 0000", R1_out);
    end
  endtask

  initial begin
    test_reset();
    test_load_and_pre_edge();
    test_arith_wrap();
    test_alu_ops();
    test_q_shift();
    test_acc_shift();
    test_shift_boundary();
    test_q_operand();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
